// File: rtl/gc_pkg.sv
// Shared definitions for the GameCube controller bridge: poll command,
// FSM states and report byte positions.
package gc_pkg;

  localparam int unsigned CMD_LEN = 24;
  localparam logic [CMD_LEN-1:0] POLL_CMD = 24'h400300;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } gc_state_e;

  // Report byte positions; byte0 is the first byte received.
  localparam int unsigned BYTE_STICK_X  = 2;
  localparam int unsigned BYTE_STICK_Y  = 3;
  localparam int unsigned BYTE_CSTICK_X = 4;
  localparam int unsigned BYTE_CSTICK_Y = 5;
  localparam int unsigned BYTE_TRIG_R   = 7;

  function automatic logic [7:0] report_byte(input logic [63:0] rpt, input int unsigned idx);
    return rpt[(63 - 8 * idx) -: 8];
  endfunction

endpackage

// File: rtl/gc_pwm8.sv
// 8-bit PWM comparator against a shared free-running step counter.
module gc_pwm8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty,
  input  logic [7:0] count,
  output logic       pwm
);

  always_ff @(posedge clk) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= (count < duty);
  end

endmodule

// File: rtl/gc_controller_bridge.sv
// Polls a GameCube controller on its open-drain line, latches the 64-bit report
// and drives motor PWMs and RC-servo pulses from its analog fields.
module gc_controller_bridge
  import gc_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 10_000_000,
  parameter int unsigned POLL_CYCLES     = 100_000,
  parameter int unsigned TIMEOUT_US      = 100,
  parameter int unsigned PWM_DIV         = 16,
  parameter int unsigned SERVO_PERIOD_US = 20_000
) (
  input  logic        SYSCLK,
  input  logic        MSS_RESET_N,
  input  logic        CAPTURE_SWITCH,
  input  logic        UART_0_RXD,
  output logic        UART_0_TXD,
  inout  wire         data,
  output logic        start_count,
  output logic        send,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic        PWM1,
  output logic        LMOTOR,
  output logic        RMOTOR,
  output logic        LSERVO,
  output logic        RSERVO
);

  localparam int unsigned US_CYC     = CLK_HZ / 1_000_000;
  localparam int unsigned BIT_CYC    = 4 * US_CYC;
  localparam int unsigned SAMPLE_CYC = 2 * US_CYC;
  localparam int unsigned TO_CYC     = TIMEOUT_US * US_CYC;
  localparam int unsigned POLL_W     = $clog2(POLL_CYCLES);
  localparam int unsigned BIT_W      = $clog2(BIT_CYC);
  localparam int unsigned TO_W       = $clog2(TO_CYC + 1);
  localparam int unsigned US_W       = $clog2(US_CYC + 1);
  localparam int unsigned DIV_W      = $clog2(PWM_DIV + 1);
  localparam int unsigned SRV_W      = $clog2(SERVO_PERIOD_US + 2048);

  gc_state_e         state_q, state_n;
  logic [POLL_W-1:0] poll_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [4:0]        tx_idx;
  logic [TO_W-1:0]   to_cnt;
  logic [BIT_W-1:0]  ph;
  logic              armed;
  logic [6:0]        rx_cnt;
  logic [63:0]       shift;
  logic              line_meta, line_sync, line_prev, drive;
  logic              fall_c, poll_hit_c, bit_end_c, to_hit_c;
  logic              tx_bit_c, drive_c, send_c, start_c, publish_c;

  assign data = drive ? 1'b0 : 1'bz;

  assign fall_c     = line_prev & ~line_sync;
  assign poll_hit_c = CAPTURE_SWITCH && (poll_cnt == POLL_W'(POLL_CYCLES - 1));
  assign bit_end_c  = (bit_cnt == BIT_W'(BIT_CYC - 1));
  assign to_hit_c   = (to_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge SYSCLK) begin
    if (!MSS_RESET_N) state_q <= ST_IDLE;
    else              state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (poll_hit_c) state_n = ST_SEND;
      ST_SEND: if ((tx_idx == 5'(CMD_LEN)) && bit_end_c) state_n = ST_WAIT;
      ST_WAIT: begin
        if (fall_c)        state_n = ST_RECV;
        else if (to_hit_c) state_n = ST_IDLE;
      end
      ST_RECV: begin
        if (fall_c && (rx_cnt == 7'd64)) state_n = ST_DONE;
        else if (to_hit_c)               state_n = ST_IDLE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Bit index CMD_LEN is the trailing stop bit, always encoded as "1".
  always_comb begin
    tx_bit_c  = 1'b1;
    drive_c   = 1'b0;
    send_c    = (state_n == ST_SEND);
    start_c   = (state_q == ST_IDLE) && poll_hit_c;
    publish_c = (state_q == ST_DONE);
    if (tx_idx < 5'(CMD_LEN)) tx_bit_c = POLL_CMD[5'(CMD_LEN - 1) - tx_idx];
    if (state_q == ST_SEND)
      drive_c = bit_cnt < (tx_bit_c ? BIT_W'(US_CYC) : BIT_W'(3 * US_CYC));
  end

  always_ff @(posedge SYSCLK) begin
    if (!MSS_RESET_N) begin
      line_meta   <= 1'b1;
      line_sync   <= 1'b1;
      line_prev   <= 1'b1;
      UART_0_TXD  <= 1'b1;
      start_count <= 1'b0;
      send        <= 1'b0;
      drive       <= 1'b0;
      poll_cnt    <= '0;
    end else begin
      line_meta   <= data;
      line_sync   <= line_meta;
      line_prev   <= line_sync;
      UART_0_TXD  <= UART_0_RXD;
      start_count <= start_c;
      send        <= send_c;
      drive       <= drive_c;
      if (CAPTURE_SWITCH) poll_cnt <= poll_hit_c ? '0 : poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!MSS_RESET_N || (state_q != ST_SEND)) begin
      bit_cnt <= '0;
      tx_idx  <= '0;
    end else if (bit_end_c) begin
      bit_cnt <= '0;
      tx_idx  <= tx_idx + 5'd1;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Idle-line timer restarts on every falling edge while awaiting/receiving.
  always_ff @(posedge SYSCLK) begin
    if (!MSS_RESET_N) to_cnt <= '0;
    else if (((state_q == ST_WAIT) || (state_q == ST_RECV)) && !fall_c) to_cnt <= to_cnt + 1'b1;
    else to_cnt <= '0;
  end

  always_ff @(posedge SYSCLK) begin
    if (!MSS_RESET_N) begin
      armed  <= 1'b0;
      ph     <= '0;
      rx_cnt <= '0;
      shift  <= '0;
    end else if (state_q == ST_WAIT) begin
      armed  <= fall_c;
      ph     <= '0;
      rx_cnt <= '0;
    end else if (state_q == ST_RECV) begin
      if (fall_c) begin
        armed <= 1'b1;
        ph    <= '0;
      end else if (armed) begin
        if (ph == BIT_W'(SAMPLE_CYC - 1)) begin
          shift  <= {shift[62:0], line_sync};
          rx_cnt <= rx_cnt + 7'd1;
          armed  <= 1'b0;
        end else begin
          ph <= ph + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!MSS_RESET_N) begin
      data1 <= '0;
      data2 <= '0;
    end else if (publish_c) begin
      data1 <= shift[63:32];
      data2 <= shift[31:0];
    end
  end

  logic [63:0]      rpt;
  logic [DIV_W-1:0] pwm_div;
  logic [7:0]       pwm_cnt;
  logic [US_W-1:0]  us_div;
  logic [SRV_W-1:0] us_cnt, lservo_thr, rservo_thr;

  assign rpt        = {data1, data2};
  assign lservo_thr = SRV_W'(1000) + SRV_W'({report_byte(rpt, BYTE_STICK_X), 2'b00});
  assign rservo_thr = SRV_W'(1000) + SRV_W'({report_byte(rpt, BYTE_CSTICK_X), 2'b00});

  always_ff @(posedge SYSCLK) begin
    if (!MSS_RESET_N) begin
      pwm_div <= '0;
      pwm_cnt <= '0;
      us_div  <= '0;
      us_cnt  <= '0;
      LSERVO  <= 1'b0;
      RSERVO  <= 1'b0;
    end else begin
      if (pwm_div == DIV_W'(PWM_DIV - 1)) begin
        pwm_div <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pwm_div <= pwm_div + 1'b1;
      end
      if (us_div == US_W'(US_CYC - 1)) begin
        us_div <= '0;
        us_cnt <= (us_cnt == SRV_W'(SERVO_PERIOD_US - 1)) ? '0 : us_cnt + 1'b1;
      end else begin
        us_div <= us_div + 1'b1;
      end
      LSERVO <= (us_cnt < lservo_thr);
      RSERVO <= (us_cnt < rservo_thr);
    end
  end

  gc_pwm8 u_pwm_trig (.clk(SYSCLK), .rst_n(MSS_RESET_N), .duty(report_byte(rpt, BYTE_TRIG_R)),
                      .count(pwm_cnt), .pwm(PWM1));
  gc_pwm8 u_pwm_left (.clk(SYSCLK), .rst_n(MSS_RESET_N), .duty(report_byte(rpt, BYTE_STICK_Y)),
                      .count(pwm_cnt), .pwm(LMOTOR));
  gc_pwm8 u_pwm_right (.clk(SYSCLK), .rst_n(MSS_RESET_N), .duty(report_byte(rpt, BYTE_CSTICK_Y)),
                       .count(pwm_cnt), .pwm(RMOTOR));

endmodule

// File: tb/tb_gc_controller_bridge.sv
// Directed bench for gc_controller_bridge with a simple controller line model.
module tb_gc_controller_bridge;

  localparam int unsigned CLK_HZ  = 4_000_000;
  localparam int unsigned POLL    = 4000;
  localparam int unsigned TO_US   = 100;
  localparam int unsigned PDIV    = 2;
  localparam int unsigned SRV_US  = 2500;
  localparam int unsigned US      = CLK_HZ / 1_000_000;
  localparam int unsigned BITC    = 4 * US;
  localparam int unsigned PWM_PER = 256 * PDIV;
  localparam int unsigned SRV_PER = SRV_US * US;

  logic        clk = 1'b0;
  logic        rst_n, cap, rxd, tb_low;
  logic        txd, start_count, send, pwm1, lmotor, rmotor, lservo, rservo;
  logic [31:0] data1, data2;
  wire         gc_line;
  int          n_checks, n_fail;

  always #5 clk = ~clk;

  assign gc_line = tb_low ? 1'b0 : 1'bz;
  pullup (gc_line);

  gc_controller_bridge #(
    .CLK_HZ(CLK_HZ), .POLL_CYCLES(POLL), .TIMEOUT_US(TO_US),
    .PWM_DIV(PDIV), .SERVO_PERIOD_US(SRV_US)
  ) dut (
    .SYSCLK(clk), .MSS_RESET_N(rst_n), .CAPTURE_SWITCH(cap),
    .UART_0_RXD(rxd), .UART_0_TXD(txd), .data(gc_line),
    .start_count(start_count), .send(send), .data1(data1), .data2(data2),
    .PWM1(pwm1), .LMOTOR(lmotor), .RMOTOR(rmotor), .LSERVO(lservo), .RSERVO(rservo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < int'(POLL) + 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (start_count === 1'b1) found = 1'b1;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  // Watches the line through the command phase and decodes pulse widths.
  task automatic decode_cmd();
    int          send_cyc, start_cyc, run, nbits;
    logic [24:0] word;
    logic        bad;
    send_cyc = 0; start_cyc = 0; run = 0; nbits = 0; word = '0; bad = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (send === 1'b1) send_cyc++;
      if (start_count === 1'b1) start_cyc++;
      if (gc_line === 1'b0) run++;
      else if (run > 0) begin
        nbits++;
        word = {word[23:0], (run == int'(US))};
        if (run != int'(US) && run != int'(3 * US)) bad = 1'b1;
        run = 0;
      end
    end
    check("send_width", 64'(send_cyc), 64'(25 * BITC));
    check("start_pulse_width", 64'(start_cyc), 64'd1);
    check("cmd_bit_count", 64'(nbits), 64'd25);
    check("cmd_word", 64'(word), 64'h0800601);
    check("cmd_pulse_shape", 64'(bad), 64'd0);
  endtask

  task automatic reply(input logic [63:0] v, input int nbits, input bit stop);
    for (int i = 0; i < nbits; i++) begin
      int lo;
      lo = v[63 - i] ? int'(US) : int'(3 * US);
      tb_low = 1'b1;
      repeat (lo) @(negedge clk);
      tb_low = 1'b0;
      repeat (int'(BITC) - lo) @(negedge clk);
    end
    if (stop) begin
      tb_low = 1'b1;
      repeat (US) @(negedge clk);
      tb_low = 1'b0;
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int lm_hi, rm_hi, p1_hi, ls_hi, rs_hi, starts, lows;
    n_checks = 0; n_fail = 0;
    tb_low = 1'b0; rst_n = 1'b0; cap = 1'b1; rxd = 1'b0;

    repeat (10) @(negedge clk);
    check("rst_data1", 64'(data1), 64'd0);
    check("rst_data2", 64'(data2), 64'd0);
    check("rst_send", 64'(send), 64'd0);
    check("rst_start", 64'(start_count), 64'd0);
    check("rst_pwm1", 64'(pwm1), 64'd0);
    check("rst_lmotor", 64'(lmotor), 64'd0);
    check("rst_rmotor", 64'(rmotor), 64'd0);
    check("rst_line", 64'(gc_line), 64'd1);
    check("rst_txd", 64'(txd), 64'd1);
    rst_n = 1'b1;

    repeat (POLL - 1) @(posedge clk);
    #1 check("start_early", 64'(start_count), 64'd0);
    @(posedge clk);
    #1 check("start_at_poll", 64'(start_count), 64'd1);
    decode_cmd();
    reply(64'h0080_8080_8080_2040, 64, 1'b1);
    cap = 1'b0;
    check("r1_data1", 64'(data1), 64'h0080_8080);
    check("r1_data2", 64'(data2), 64'h8080_2040);

    // Three poll periods with polling suspended.
    lm_hi = 0; rm_hi = 0; p1_hi = 0; ls_hi = 0; rs_hi = 0; starts = 0; lows = 0;
    for (int i = 0; i < int'(3 * POLL); i++) begin
      @(negedge clk);
      if (i < int'(PWM_PER)) begin
        lm_hi += int'(lmotor); rm_hi += int'(rmotor); p1_hi += int'(pwm1);
      end
      if (i < int'(SRV_PER)) begin
        ls_hi += int'(lservo); rs_hi += int'(rservo);
      end
      starts += int'(start_count === 1'b1);
      lows   += int'(gc_line === 1'b0);
    end
    check("r1_lmotor_duty", 64'(lm_hi), 64'(128 * PDIV));
    check("r1_rmotor_duty", 64'(rm_hi), 64'(128 * PDIV));
    check("r1_pwm1_duty", 64'(p1_hi), 64'(64 * PDIV));
    check("r1_lservo_width", 64'(ls_hi), 64'(1512 * US));
    check("r1_rservo_width", 64'(rs_hi), 64'(1512 * US));
    check("off_no_start", 64'(starts), 64'd0);
    check("off_line_idle", 64'(lows), 64'd0);
    check("off_data1_frozen", 64'(data1), 64'h0080_8080);

    cap = 1'b1;
    wait_start("resume_start");
    decode_cmd();
    reply(64'hFFFF_FFFF_FFFF_FFFF, 30, 1'b0);
    repeat (500) @(negedge clk);
    check("abort_data1_kept", 64'(data1), 64'h0080_8080);
    check("abort_data2_kept", 64'(data2), 64'h8080_2040);

    wait_start("post_abort_start");
    decode_cmd();
    reply(64'h0123_00FF_FF00_45FF, 64, 1'b1);
    cap = 1'b0;
    check("r2_data1", 64'(data1), 64'h0123_00FF);
    check("r2_data2", 64'(data2), 64'hFF00_45FF);
    lm_hi = 0; rm_hi = 0; p1_hi = 0; ls_hi = 0; rs_hi = 0;
    for (int i = 0; i < int'(SRV_PER); i++) begin
      @(negedge clk);
      if (i < int'(PWM_PER)) begin
        lm_hi += int'(lmotor); rm_hi += int'(rmotor); p1_hi += int'(pwm1);
      end
      ls_hi += int'(lservo); rs_hi += int'(rservo);
    end
    check("r2_lmotor_full", 64'(lm_hi), 64'(255 * PDIV));
    check("r2_rmotor_zero", 64'(rm_hi), 64'd0);
    check("r2_pwm1_full", 64'(p1_hi), 64'(255 * PDIV));
    check("r2_lservo_min", 64'(ls_hi), 64'(1000 * US));
    check("r2_rservo_max", 64'(rs_hi), 64'(2020 * US));

    rxd = 1'b1;
    check("uart_before_edge", 64'(txd), 64'd0);
    @(posedge clk);
    #1 check("uart_rise", 64'(txd), 64'd1);
    @(negedge clk);
    rxd = 1'b0;
    @(posedge clk);
    #1 check("uart_fall", 64'(txd), 64'd0);

    cap = 1'b1;
    wait_start("final_start");
    repeat (3) @(negedge clk);
    check("send_line_low", 64'(gc_line), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check("rst_mid_line", 64'(gc_line), 64'd1);
    check("rst_mid_send", 64'(send), 64'd0);
    check("rst_mid_data1", 64'(data1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
